// File: rtl/issue_rr_arbiter.sv
// Round-robin issue arbiter: picks one eligible wavefront per cycle and emits a
// registered one-cycle issue pulse that also drives the valid tracker's clear inputs.
module issue_rr_arbiter #(
    parameter int WF_PER_CU    = 40,
    parameter int WF_ID_LENGTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WF_PER_CU-1:0]    valid_entry,
    input  logic [WF_PER_CU-1:0]    ready_mask,
    input  logic                    fu_ready,
    input  logic                    flush_en,
    input  logic [WF_ID_LENGTH-1:0] flush_wfid,
    output logic                    issue_valid,
    output logic [WF_ID_LENGTH-1:0] issue_wfid
);

    localparam logic [WF_ID_LENGTH-1:0] LAST_WF = WF_ID_LENGTH'(WF_PER_CU - 1);

    logic [WF_ID_LENGTH-1:0] rr_ptr;
    logic [WF_PER_CU-1:0]    last_mask;
    logic [WF_PER_CU-1:0]    flush_mask;
    logic [WF_PER_CU-1:0]    eligible;
    logic                    sel_found;
    logic [WF_ID_LENGTH-1:0] sel_idx;
    logic                    wrap_found;
    logic [WF_ID_LENGTH-1:0] wrap_idx;
    logic                    issue_now;

    // Out-of-range flush ids (>= WF_PER_CU) match no slot and are ignored.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        flush_mask = '0;
        if (flush_en && (int'(flush_wfid) < WF_PER_CU)) begin
            flush_mask[flush_wfid] = 1'b1;
        end
    end

    assign eligible  = valid_entry & ready_mask & ~last_mask & ~flush_mask;
    assign issue_now = fu_ready && (|eligible);

    // Circular search from rr_ptr: lowest eligible at or above the pointer wins,
    // otherwise fall back to the lowest eligible overall (the wrapped part).
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        wrap_found = 1'b0;
        wrap_idx   = '0;
        for (int i = WF_PER_CU - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                wrap_found = 1'b1;
                wrap_idx   = WF_ID_LENGTH'(i);
                if (i >= int'(rr_ptr)) begin
                    sel_found = 1'b1;
                    sel_idx   = WF_ID_LENGTH'(i);
                end
            end
        end
        if (!sel_found) begin
            sel_found = wrap_found;
            sel_idx   = wrap_idx;
        end
    end

    // last_mask shadows the issued WF for one cycle, covering the tracker's clear lag.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid <= 1'b0;
            issue_wfid  <= '0;
            rr_ptr      <= '0;
            last_mask   <= '0;
        end else if (issue_now) begin
            issue_valid <= 1'b1;
            issue_wfid  <= sel_idx;
            rr_ptr      <= (sel_idx == LAST_WF) ? '0 : sel_idx + 1'b1;
            last_mask   <= WF_PER_CU'(1) << sel_idx;
        end else begin
            issue_valid <= 1'b0;
            last_mask   <= '0;
        end
    end

endmodule
